// File: rtl/retospect_fpna_pkg.sv
// Shared definitions for FPNA array tiles.
// Holds the default clockbus geometry, the config-chain field map and the
// saturating adder that the neuron cell shares with its clockbox successor.
package retospect_fpna_pkg;

    localparam int CLKBUS_W = 8;
    localparam int SEL_W    = $clog2(CLKBUS_W);

    // Which of the three actions the cell takes on the next edge.
    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_CFG   = 2'd1,
        MODE_CLEAR = 2'd2
    } cnb_mode_e;

    // Config chain layout, LSB upward: decay_sel, refrac, thresh, w[N-1]..w[0].
    function automatic int cfg_len(int nd, int ww, int pw, int rw, int sw);
        return nd*ww + pw + rw + sw;
    endfunction

    function automatic int off_refrac(int sw);
        return sw;
    endfunction

    function automatic int off_thresh(int rw, int sw);
        return sw + rw;
    endfunction

    // w[0] sits at the MSBs, so index i counts down from the top.
    function automatic int off_w(int i, int nd, int ww, int pw, int rw, int sw);
        return sw + rw + pw + (nd - 1 - i)*ww;
    endfunction

    // a + b clamped to the signed range of a pw-bit value.
    function automatic logic signed [31:0] sat_add(logic signed [31:0] a,
                                                   logic signed [31:0] b,
                                                   int pw);
        logic signed [31:0] s;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        s  = a + b;
        hi = (32'sd1 <<< (pw - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (s > hi)      return hi;
        else if (s < lo) return lo;
        else             return s;
    endfunction

endpackage

// File: rtl/retospect_cnb_gen2_if.sv
// Neuron cell bus: network clear, config chain, decay clockbus, dendrites in;
// axon spike and membrane potential out.
//   master : drives the cell (array fabric / testbench)
//   slave  : the neuron cell itself
interface retospect_cnb_gen2_if #(
    parameter int NUM_DEND = 4,
    parameter int CLKBUS_W = retospect_fpna_pkg::CLKBUS_W,
    parameter int POT_W    = 8
);
    logic                nn_clear;
    logic                config_en;
    logic                bs_in;
    logic                bs_out;
    logic [CLKBUS_W-1:0] clockbus;
    logic [NUM_DEND-1:0] dendrite;
    logic                axon;
    logic [POT_W-1:0]    potential;

    modport master (
        output nn_clear, config_en, bs_in, clockbus, dendrite,
        input  bs_out, axon, potential
    );

    modport slave (
        input  nn_clear, config_en, bs_in, clockbus, dendrite,
        output bs_out, axon, potential
    );
endinterface

// File: rtl/retospect_dend_sum.sv
// Combinational sum of the signed weights of every active dendrite.
//   weights  : NUM_DEND packed signed W_W-bit weights
//   dendrite : spike inputs gating each weight
//   sum      : sign-extended total, SUM_W wide (wide enough to never overflow)
module retospect_dend_sum #(
    parameter int NUM_DEND = 4,
    parameter int W_W      = 4,
    parameter int SUM_W    = 11
) (
    input  logic [NUM_DEND-1:0][W_W-1:0] weights,
    input  logic [NUM_DEND-1:0]          dendrite,
    output logic signed [SUM_W-1:0]      sum
);

    logic signed [NUM_DEND-1:0][SUM_W-1:0] gated;

    for (genvar i = 0; i < NUM_DEND; i++) begin : g_gate
        assign gated[i] = dendrite[i] ? SUM_W'($signed(weights[i])) : '0;
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_DEND; i++)
            sum = sum + $signed(gated[i]);
    end

endmodule

// File: rtl/retospect_cnb_gen2.sv
// Second-generation FPNA neuron cell.
// Signed weighted dendrites, saturating leaky membrane potential, programmable
// threshold / refractory period / leak strobe, configured by a daisy-chained
// bitstream shift register.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.slave  : nn_clear, config_en, bs_in/bs_out, clockbus, dendrite,
//                axon (one-cycle registered spike), potential
module retospect_cnb_gen2 #(
    parameter int NUM_DEND = 4,
    parameter int W_W      = 4,
    parameter int POT_W    = 8,
    parameter int REF_W    = 3,
    parameter int CLKBUS_W = retospect_fpna_pkg::CLKBUS_W,
    parameter int INIT_POT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    retospect_cnb_gen2_if.slave bus
);

    localparam int SEL_W   = $clog2(CLKBUS_W);
    localparam int CFG_LEN = retospect_fpna_pkg::cfg_len(NUM_DEND, W_W, POT_W, REF_W, SEL_W);
    localparam int SUM_W   = POT_W + $clog2(NUM_DEND) + 1;
    localparam int OFF_REF = retospect_fpna_pkg::off_refrac(SEL_W);
    localparam int OFF_TH  = retospect_fpna_pkg::off_thresh(REF_W, SEL_W);
    localparam int CB_EXT  = 1 << SEL_W;

    logic [CFG_LEN-1:0]           cfg;
    logic signed [POT_W-1:0]      pot;
    logic [REF_W-1:0]             ref_cnt;
    logic                         axon_q;

    logic [SEL_W-1:0]             decay_sel;
    logic [REF_W-1:0]             refrac;
    logic signed [POT_W-1:0]      thresh;
    logic [NUM_DEND-1:0][W_W-1:0] w_pk;

    assign decay_sel = cfg[SEL_W-1:0];
    assign refrac    = cfg[OFF_REF +: REF_W];
    assign thresh    = cfg[OFF_TH +: POT_W];

    for (genvar i = 0; i < NUM_DEND; i++) begin : g_w
        localparam int OFF = retospect_fpna_pkg::off_w(i, NUM_DEND, W_W, POT_W, REF_W, SEL_W);
        assign w_pk[i] = cfg[OFF +: W_W];
    end

    logic signed [SUM_W-1:0] dsum;

    retospect_dend_sum #(
        .NUM_DEND (NUM_DEND),
        .W_W      (W_W),
        .SUM_W    (SUM_W)
    ) u_dend_sum (
        .weights  (w_pk),
        .dendrite (bus.dendrite),
        .sum      (dsum)
    );

    // Zero-extend the clockbus to every selectable index so an out-of-range
    // decay_sel reads a constant 0 (no leak).
    logic [CB_EXT-1:0]       cb_ext;
    logic                    leak;
    logic signed [POT_W-1:0] leaked;
    logic signed [31:0]      next_w;
    logic signed [POT_W-1:0] nxt;
    logic                    fire;

    assign cb_ext = CB_EXT'(bus.clockbus);
    assign leak   = cb_ext[decay_sel];
    assign leaked = leak ? (pot >>> 1) : pot;
    assign next_w = retospect_fpna_pkg::sat_add(32'(leaked), 32'(dsum), POT_W);
    assign nxt    = next_w[POT_W-1:0];
    assign fire   = (nxt >= thresh);

    retospect_fpna_pkg::cnb_mode_e mode;

    always_comb begin
        mode = retospect_fpna_pkg::MODE_RUN;
        if (bus.nn_clear)       mode = retospect_fpna_pkg::MODE_CLEAR;
        else if (bus.config_en) mode = retospect_fpna_pkg::MODE_CFG;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg     <= '0;
            pot     <= '0;
            ref_cnt <= '0;
            axon_q  <= 1'b0;
        end else begin
            case (mode)
                retospect_fpna_pkg::MODE_CLEAR: begin
                    pot     <= POT_W'(INIT_POT);
                    ref_cnt <= '0;
                    axon_q  <= 1'b0;
                end
                retospect_fpna_pkg::MODE_CFG: begin
                    // Dynamic state is frozen while the chain shifts.
                    cfg    <= {bus.bs_in, cfg[CFG_LEN-1:1]};
                    axon_q <= 1'b0;
                end
                default: begin
                    if (ref_cnt != '0) begin
                        ref_cnt <= ref_cnt - REF_W'(1);
                        pot     <= '0;
                        axon_q  <= 1'b0;
                    end else if (fire) begin
                        axon_q  <= 1'b1;
                        pot     <= '0;
                        ref_cnt <= refrac;
                    end else begin
                        axon_q  <= 1'b0;
                        pot     <= nxt;
                    end
                end
            endcase
        end
    end

    assign bus.bs_out    = cfg[0];
    assign bus.axon      = axon_q;
    assign bus.potential = pot;

endmodule
